// File: rtl/bop_crash_sequencer_pkg.sv
// Shared types and defaults for the BOP crash-response sequencer.
package bop_crash_sequencer_pkg;

  typedef enum logic [1:0] {
    BOP_IDLE,
    BOP_ARMED,
    BOP_LOCKED
  } bop_seq_state_e;

  typedef struct packed {
    logic lib;
    logic varleak;
    logic dderef;
  } bop_cause_t;

  localparam int unsigned BOP_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/bop_crash_sequencer_sat_counter.sv
// Saturating up-counter; holds at all-ones, cleared only by reset.
module bop_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/bop_crash_sequencer.sv
// Violation-response controller: arms on BOP violations, forces the next jump
// target to zero (or raises a timeout), and locks until software clear.
module bop_crash_sequencer
  import bop_crash_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = BOP_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_crash_i,
  input  logic             debug_mode_i,
  input  logic             viol_dderef_i,
  input  logic             viol_varleak_i,
  input  logic             viol_lib_i,
  input  logic             branch_valid_i,
  input  logic             is_jump_i,
  input  logic             clear_i,
  output logic             force_zero_o,
  output logic             armed_o,
  output logic             locked_o,
  output logic             timeout_o,
  output logic [2:0]       cause_o,
  output logic [CNT_W-1:0] viol_cnt_o
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  bop_seq_state_e state;
  bop_cause_t     cause;
  bop_cause_t     flags;
  logic [TW-1:0]  timer;
  logic           viol;
  logic           jump_now;
  logic           timer_done;

  assign flags      = '{lib: viol_lib_i, varleak: viol_varleak_i, dderef: viol_dderef_i};
  assign viol       = en_crash_i & ~debug_mode_i & (|flags);
  assign jump_now   = branch_valid_i & is_jump_i;
  assign timer_done = (timer == TW'(TIMEOUT - 1));
  assign cause_o    = cause;

  // clear_i deliberately absent: LOCKED keeps forcing in the clear cycle.
  always_comb begin
    force_zero_o = 1'b0;
    unique case (state)
      BOP_IDLE:   force_zero_o = viol & jump_now;
      BOP_ARMED:  force_zero_o = en_crash_i & ~debug_mode_i & jump_now;
      BOP_LOCKED: force_zero_o = branch_valid_i & ~debug_mode_i;
      default:    force_zero_o = 1'b0;
    endcase
  end

  assign timeout_o = (state == BOP_ARMED) & en_crash_i & ~debug_mode_i &
                     ~jump_now & timer_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= BOP_IDLE;
      timer    <= '0;
      cause    <= '0;
      armed_o  <= 1'b0;
      locked_o <= 1'b0;
    end else begin
      unique case (state)
        BOP_IDLE: begin
          if (viol) begin
            cause    <= flags;
            timer    <= '0;
            state    <= jump_now ? BOP_LOCKED : BOP_ARMED;
            armed_o  <= ~jump_now;
            locked_o <= jump_now;
          end
        end
        BOP_ARMED: begin
          if (!en_crash_i) begin
            state   <= BOP_IDLE;
            cause   <= '0;
            armed_o <= 1'b0;
          end else if (!debug_mode_i) begin
            cause <= bop_cause_t'(cause | flags);
            if (jump_now || timer_done) begin
              state    <= BOP_LOCKED;
              armed_o  <= 1'b0;
              locked_o <= 1'b1;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end
        BOP_LOCKED: begin
          // A violation in the clear cycle is taken as if already back in IDLE.
          if (clear_i) begin
            if (viol) begin
              cause    <= flags;
              timer    <= '0;
              state    <= jump_now ? BOP_LOCKED : BOP_ARMED;
              armed_o  <= ~jump_now;
              locked_o <= jump_now;
            end else begin
              cause    <= '0;
              state    <= BOP_IDLE;
              locked_o <= 1'b0;
            end
          end else if (viol) begin
            cause <= bop_cause_t'(cause | flags);
          end
        end
        default: begin
          state    <= BOP_IDLE;
          cause    <= '0;
          armed_o  <= 1'b0;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

  bop_sat_counter #(
    .WIDTH(CNT_W)
  ) u_viol_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (viol),
    .count_o(viol_cnt_o)
  );

endmodule
